// File: rtl/tx_framer_if.sv
// Byte-stream and transmitter handshake bundle for tx_framer.
// master: protocol layer plus transmitter side; slave: the framer.
interface tx_framer_if;
  logic [7:0] in_data;
  logic [2:0] in_bits;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       append_crc;
  logic [7:0] data;
  logic [2:0] data_bits;
  logic       ready_to_send;
  logic       req;

  modport master (
    output in_data, in_bits, in_last, in_valid, append_crc, req,
    input  in_ready, data, data_bits, ready_to_send
  );

  modport slave (
    input  in_data, in_bits, in_last, in_valid, append_crc, req,
    output in_ready, data, data_bits, ready_to_send
  );
endinterface

// File: rtl/tx_framer.sv
// Frames an upstream byte stream for the PICC transmitter, one holding slot deep.
// Define TX_FRAMER_CRC_EN to build the optional trailing CRC_A (LSB byte first).
module tx_framer #(
  parameter logic [15:0] CRC_INIT = 16'h6363
) (
  input  logic        clk,
  input  logic        rst,
  tx_framer_if.slave  bus,
  output logic        busy,
  output logic        frame_done
);

`ifdef TX_FRAMER_CRC_EN
  typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t     state, state_n;
  logic [7:0] slot_data, slot_data_n;
  logic [2:0] slot_bits, slot_bits_n;
  logic       slot_full, slot_full_n;
  logic       last_acc, last_acc_n;
  logic       done_q, done_n;
  logic       accept, full_byte;
  logic [2:0] eff_bits;

`ifdef TX_FRAMER_CRC_EN
  logic        crc_en, crc_en_n;
  logic [15:0] crc, crc_n;

  // Reflected CRC-16 (poly 0x8408), one byte per call, LSB of data first.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
`else
  logic crc_unused;
  assign crc_unused = ^{bus.append_crc, CRC_INIT};
`endif

  assign bus.in_ready      = !slot_full && (state == IDLE || state == DATA) && !last_acc;
  assign bus.data          = slot_data;
  assign bus.data_bits     = slot_bits;
  assign bus.ready_to_send = slot_full;
  assign frame_done        = done_q;
  assign busy              = (state != IDLE) || done_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign eff_bits  = bus.in_last ? bus.in_bits : 3'd0;
  assign full_byte = (eff_bits == 3'd0);

  always_comb begin
    state_n     = state;
    slot_data_n = slot_data;
    slot_bits_n = slot_bits;
    slot_full_n = slot_full;
    last_acc_n  = last_acc;
    done_n      = 1'b0;
`ifdef TX_FRAMER_CRC_EN
    crc_en_n    = crc_en;
    crc_n       = crc;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          slot_data_n = bus.in_data;
          slot_bits_n = eff_bits;
          slot_full_n = 1'b1;
          last_acc_n  = bus.in_last;
          state_n     = DATA;
`ifdef TX_FRAMER_CRC_EN
          crc_en_n = bus.append_crc && full_byte;
          crc_n    = full_byte ? crc_upd(CRC_INIT, bus.in_data) : CRC_INIT;
`endif
        end
      end
      DATA: begin
        if (accept) begin
          slot_data_n = bus.in_data;
          slot_bits_n = eff_bits;
          slot_full_n = 1'b1;
          last_acc_n  = bus.in_last;
`ifdef TX_FRAMER_CRC_EN
          // A partial trailing byte means a short frame: never carries CRC.
          if (full_byte) crc_n = crc_upd(crc, bus.in_data);
          else           crc_en_n = 1'b0;
`endif
        end else if (bus.req && slot_full) begin
          if (!last_acc) begin
            slot_full_n = 1'b0;
`ifdef TX_FRAMER_CRC_EN
          end else if (crc_en) begin
            slot_data_n = crc[7:0];
            slot_bits_n = 3'd0;
            state_n     = CRC_LO;
`endif
          end else begin
            slot_full_n = 1'b0;
            last_acc_n  = 1'b0;
            done_n      = 1'b1;
            state_n     = IDLE;
          end
        end
      end
`ifdef TX_FRAMER_CRC_EN
      CRC_LO: begin
        if (bus.req) begin
          slot_data_n = crc[15:8];
          state_n     = CRC_HI;
        end
      end
      CRC_HI: begin
        if (bus.req) begin
          slot_full_n = 1'b0;
          last_acc_n  = 1'b0;
          done_n      = 1'b1;
          state_n     = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_data <= 8'd0;
      slot_bits <= 3'd0;
      slot_full <= 1'b0;
      last_acc  <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
      crc_en    <= 1'b0;
      crc       <= CRC_INIT;
`endif
    end else begin
      state     <= state_n;
      slot_data <= slot_data_n;
      slot_bits <= slot_bits_n;
      slot_full <= slot_full_n;
      last_acc  <= last_acc_n;
      done_q    <= done_n;
`ifdef TX_FRAMER_CRC_EN
      crc_en    <= crc_en_n;
      crc       <= crc_n;
`endif
    end
  end

endmodule
